namuru_siggen: RTL and testbench
================================

Name: namuru_siggen

Overview:
- Synthetic GPS L1 C/A front-end sample generator, single clock domain.
- Produces the 1-bit sign / 1-bit mag sample stream that the correlator channel consumes.
- Used for loopback self-test and bench stimulus of the correlator path.
- Generates one PRN's Gold code, advanced by a code NCO and modulated by a 2-bit quantised carrier from a carrier NCO.

Parameters:
- NCO_W, 32, width of the carrier and code phase accumulators and their frequency control words.

Ports:
- sys_clk  in  1  clock.
- sys_rst  in  1  synchronous, active-high reset.
- enable  in  1  advance generator one sample per cycle while high.
- cfg_load  in  1  single-cycle pulse; latch configuration and restart generator.
- prn_tap1  in  4  G2 phase-selector tap A, legal range 1..10.
- prn_tap2  in  4  G2 phase-selector tap B, legal range 1..10.
- carr_fcw  in  NCO_W  carrier phase increment per sample.
- code_fcw  in  NCO_W  code phase increment per sample.
- sign  out  1  sample sign bit.
- mag  out  1  sample magnitude bit.
- sample_valid  out  1  sign/mag updated this cycle.
- chip_strobe  out  1  code advanced to next chip this cycle.
- epoch  out  1  code period wrap (chip 1022 -> 0).
- chip_cnt  out  10  current chip index, 0..1022.

Behaviour:
- One clock (sys_clk); reset is synchronous and active-high (sys_rst).
- Reset values:
  - sign, mag, sample_valid, chip_strobe, epoch = 0; chip_cnt = 0.
  - G1 and G2 LFSRs = all ones; carrier and code phase = 0.
  - Latched taps = 2, 6 (PRN1); latched FCWs = 0.
- Invalid taps: a tap value outside 1..10 is replaced by 1 at latch time. Equal taps are legal; the G2 contribution is then 0.
- cfg_load cycle:
  - Latch taps and both FCWs.
  - Reset LFSRs to all ones, both phases to 0, chip_cnt to 0.
  - No advance that cycle; sample_valid = 0.
  - cfg_load has priority over enable.
- LFSR polynomials and current chip:
  - G1 = 1 + x^3 + x^10; G2 = 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10. Stages are numbered 1..10; stage 10 is the output.
  - chip = G1[10] ^ G2[tapA] ^ G2[tapB].
- Enabled cycle (enable=1, cfg_load=0):
  - carr_phase += carr_fcw (mod 2^NCO_W).
  - code_phase += code_fcw; a carry out of code_phase is a chip advance.
  - On chip advance:
    - Both LFSRs shift and chip_cnt increments; chip_strobe = 1 on the following cycle.
    - If chip_cnt was 1022: chip_cnt -> 0, both LFSRs are forced to all ones, epoch = 1 with chip_strobe.
  - Outputs are registered from pre-update state, one cycle latency:
    - sign = chip ^ carr_phase[NCO_W-1]
    - mag = carr_phase[NCO_W-2] ^ carr_phase[NCO_W-3]
    - sample_valid = 1
- enable=0: all state holds; sign/mag hold their last value; sample_valid, chip_strobe, epoch = 0.
- chip_strobe and epoch are single-cycle pulses.
- code_fcw = 0 freezes the code at the current chip; carr_fcw = 0 gives a constant carrier with sign = chip and mag = 0.
- A reset asserted mid-sequence overrides everything on that edge; there is no partial state.

Test Plan:
- Reset then hold enable=0 -> all outputs 0, chip_cnt=0, no pulses.
- cfg_load with taps 2,6, carr_fcw=0, code_fcw=2^31, then enable=1:
  - chip_strobe pulses every 2 cycles.
  - First 10 chips on sign = 1,1,0,0,1,0,0,0,0,0 (PRN1 octal 1440); mag=0 throughout.
- Same config, run 2046 enabled cycles:
  - epoch pulses exactly once, coincident with chip_strobe when chip_cnt returns 0.
  - Next 10 chips repeat 1440 octal.
- carr_fcw=2^30, code_fcw=0:
  - Carrier sign pattern 0,0,1,1 repeats.
  - mag pattern 0,1,0,1 repeats, XORed into sign with a constant chip.
- Deassert enable for 5 cycles mid-run:
  - State frozen, sample_valid=0.
  - On resume, the chip sequence continues without skip or repeat.
- Taps 0 and 15 loaded -> treated as 1,1: sign = G1 sequence only. cfg_load asserted together with enable -> no advance that cycle; chip_cnt=0 afterwards.

Source files
------------

// File: rtl/namuru_siggen_if.sv
// Configuration and sample-stream bundle for the synthetic GPS L1 C/A sample generator.
// The master side configures and consumes samples; the slave side is the generator.
interface namuru_siggen_if #(
  parameter int unsigned NCO_W = 32
);
  logic             enable;
  logic             cfg_load;
  logic [3:0]       prn_tap1;
  logic [3:0]       prn_tap2;
  logic [NCO_W-1:0] carr_fcw;
  logic [NCO_W-1:0] code_fcw;
  logic             sign;
  logic             mag;
  logic             sample_valid;
  logic             chip_strobe;
  logic             epoch;
  logic [9:0]       chip_cnt;

  modport master (
    output enable, cfg_load, prn_tap1, prn_tap2, carr_fcw, code_fcw,
    input  sign, mag, sample_valid, chip_strobe, epoch, chip_cnt
  );

  modport slave (
    input  enable, cfg_load, prn_tap1, prn_tap2, carr_fcw, code_fcw,
    output sign, mag, sample_valid, chip_strobe, epoch, chip_cnt
  );
endinterface

// File: rtl/namuru_siggen.sv
// Synthetic GPS L1 C/A sample generator: Gold code stepped by a code NCO, mixed with a
// 2-bit quantised carrier from a carrier NCO, emitted as registered sign/mag samples.
module namuru_siggen #(
  parameter int unsigned NCO_W = 32
) (
  input logic            sys_clk,
  input logic            sys_rst,
  namuru_siggen_if.slave sg
);

  // LFSR bit n-1 holds stage n; stage 10 is the output.
  logic [9:0]       g1_q, g1_d, g2_q, g2_d;
  logic [3:0]       tap1_q, tap1_d, tap2_q, tap2_d;
  logic [NCO_W-1:0] carr_fcw_q, carr_fcw_d, code_fcw_q, code_fcw_d;
  logic [NCO_W-1:0] carr_phase_q, carr_phase_d, code_phase_q, code_phase_d;
  logic [9:0]       chip_cnt_q, chip_cnt_d;
  logic             sign_q, sign_d, mag_q, mag_d;
  logic             valid_q, valid_d, strobe_q, strobe_d, epoch_q, epoch_d;

  logic             chip, g1_fb, g2_fb, code_carry;
  logic [NCO_W-1:0] code_sum;

  function automatic logic [3:0] clean_tap(input logic [3:0] t);
    return (t >= 4'd1 && t <= 4'd10) ? t : 4'd1;
  endfunction

  assign g1_fb = g1_q[2] ^ g1_q[9];
  assign g2_fb = g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9];
  assign chip  = g1_q[9] ^ g2_q[tap1_q - 4'd1] ^ g2_q[tap2_q - 4'd1];
  assign {code_carry, code_sum} = {1'b0, code_phase_q} + {1'b0, code_fcw_q};

  always_comb begin
    g1_d         = g1_q;
    g2_d         = g2_q;
    tap1_d       = tap1_q;
    tap2_d       = tap2_q;
    carr_fcw_d   = carr_fcw_q;
    code_fcw_d   = code_fcw_q;
    carr_phase_d = carr_phase_q;
    code_phase_d = code_phase_q;
    chip_cnt_d   = chip_cnt_q;
    sign_d       = sign_q;
    mag_d        = mag_q;
    valid_d      = 1'b0;
    strobe_d     = 1'b0;
    epoch_d      = 1'b0;
    if (sg.cfg_load) begin
      tap1_d       = clean_tap(sg.prn_tap1);
      tap2_d       = clean_tap(sg.prn_tap2);
      carr_fcw_d   = sg.carr_fcw;
      code_fcw_d   = sg.code_fcw;
      g1_d         = '1;
      g2_d         = '1;
      carr_phase_d = '0;
      code_phase_d = '0;
      chip_cnt_d   = '0;
    end else if (sg.enable) begin
      // Samples come from the pre-update phase and chip.
      sign_d       = chip ^ carr_phase_q[NCO_W-1];
      mag_d        = carr_phase_q[NCO_W-2] ^ carr_phase_q[NCO_W-3];
      valid_d      = 1'b1;
      carr_phase_d = carr_phase_q + carr_fcw_q;
      code_phase_d = code_sum;
      if (code_carry) begin
        strobe_d = 1'b1;
        if (chip_cnt_q == 10'd1022) begin
          chip_cnt_d = '0;
          g1_d       = '1;
          g2_d       = '1;
          epoch_d    = 1'b1;
        end else begin
          chip_cnt_d = chip_cnt_q + 10'd1;
          g1_d       = {g1_q[8:0], g1_fb};
          g2_d       = {g2_q[8:0], g2_fb};
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      g1_q         <= '1;
      g2_q         <= '1;
      tap1_q       <= 4'd2;
      tap2_q       <= 4'd6;
      carr_fcw_q   <= '0;
      code_fcw_q   <= '0;
      carr_phase_q <= '0;
      code_phase_q <= '0;
      chip_cnt_q   <= '0;
      sign_q       <= 1'b0;
      mag_q        <= 1'b0;
      valid_q      <= 1'b0;
      strobe_q     <= 1'b0;
      epoch_q      <= 1'b0;
    end else begin
      g1_q         <= g1_d;
      g2_q         <= g2_d;
      tap1_q       <= tap1_d;
      tap2_q       <= tap2_d;
      carr_fcw_q   <= carr_fcw_d;
      code_fcw_q   <= code_fcw_d;
      carr_phase_q <= carr_phase_d;
      code_phase_q <= code_phase_d;
      chip_cnt_q   <= chip_cnt_d;
      sign_q       <= sign_d;
      mag_q        <= mag_d;
      valid_q      <= valid_d;
      strobe_q     <= strobe_d;
      epoch_q      <= epoch_d;
    end
  end

  assign sg.sign         = sign_q;
  assign sg.mag          = mag_q;
  assign sg.sample_valid = valid_q;
  assign sg.chip_strobe  = strobe_q;
  assign sg.epoch        = epoch_q;
  assign sg.chip_cnt     = chip_cnt_q;

endmodule

// File: tb/tb_namuru_siggen.sv
// Bench for namuru_siggen: a behavioural model pushes expected samples to a scoreboard,
// each scenario task pops and compares them after every clock edge.
module tb_namuru_siggen;
  localparam int unsigned W = 32;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  namuru_siggen_if #(.NCO_W(W)) sg ();

  namuru_siggen #(.NCO_W(W)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .sg     (sg)
  );

  always #5 sys_clk = ~sys_clk;

  // {sign, mag, sample_valid, chip_strobe, epoch, chip_cnt}
  typedef logic [14:0] exp_t;
  exp_t sb[$];
  exp_t exp_v, obs_v;

  int n_run  = 0;
  int n_fail = 0;

  // Code sequences as seen on stage 10; stage n at chip k equals stage 10 at chip k+10-n.
  int g1out[1023];
  int g2out[1023];

  logic [W-1:0] m_carr, m_code, m_carr_fcw, m_code_fcw;
  int           m_k, m_ta, m_tb;
  logic         m_sign, m_mag;

  // Configuration presented on the bus during cfg_load cycles.
  int           c_ta, c_tb;
  logic [W-1:0] c_cf, c_df;

  task automatic build_codes();
    int s1[11];
    int s2[11];
    int f1, f2;
    for (int i = 1; i <= 10; i++) begin
      s1[i] = 1;
      s2[i] = 1;
    end
    for (int k = 0; k < 1023; k++) begin
      g1out[k] = s1[10];
      g2out[k] = s2[10];
      f1 = s1[3] ^ s1[10];
      f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
      for (int i = 10; i >= 2; i--) begin
        s1[i] = s1[i-1];
        s2[i] = s2[i-1];
      end
      s1[1] = f1;
      s2[1] = f2;
    end
  endtask

  // Advances the model, pushes the expected post-edge outputs, then drives one clock.
  task automatic drive_cycle(input logic rst, input logic en, input logic load);
    logic       st, ep, vl, chip;
    logic [W:0] sum;
    st = 1'b0;
    ep = 1'b0;
    vl = 1'b0;
    if (rst) begin
      m_carr = '0; m_code = '0; m_carr_fcw = '0; m_code_fcw = '0;
      m_k = 0; m_ta = 2; m_tb = 6; m_sign = 1'b0; m_mag = 1'b0;
    end else if (load) begin
      m_ta = (c_ta >= 1 && c_ta <= 10) ? c_ta : 1;
      m_tb = (c_tb >= 1 && c_tb <= 10) ? c_tb : 1;
      m_carr_fcw = c_cf;
      m_code_fcw = c_df;
      m_carr = '0;
      m_code = '0;
      m_k = 0;
    end else if (en) begin
      chip = 1'(g1out[m_k] ^ g2out[(m_k + 10 - m_ta) % 1023]
                ^ g2out[(m_k + 10 - m_tb) % 1023]);
      m_sign = chip ^ m_carr[W-1];
      m_mag  = m_carr[W-2] ^ m_carr[W-3];
      vl     = 1'b1;
      m_carr = m_carr + m_carr_fcw;
      sum    = {1'b0, m_code} + {1'b0, m_code_fcw};
      m_code = sum[W-1:0];
      if (sum[W]) begin
        st = 1'b1;
        if (m_k == 1022) begin
          m_k = 0;
          ep  = 1'b1;
        end else begin
          m_k++;
        end
      end
    end
    sb.push_back({m_sign, m_mag, vl, st, ep, 10'(m_k)});
    sys_rst     = rst;
    sg.enable   = en;
    sg.cfg_load = load;
    sg.prn_tap1 = 4'(c_ta);
    sg.prn_tap2 = 4'(c_tb);
    sg.carr_fcw = c_cf;
    sg.code_fcw = c_df;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      drive_cycle(i < 2, 1'b0, 1'b0);
      exp_v = sb.pop_front();
      obs_v = {sg.sign, sg.mag, sg.sample_valid, sg.chip_strobe, sg.epoch, sg.chip_cnt};
      n_run++;
      if (obs_v !== exp_v || obs_v !== '0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_prn1();
    logic [9:0] chips;
    int         strobes;
    chips   = '0;
    strobes = 0;
    c_ta = 2; c_tb = 6; c_cf = '0; c_df = 32'h8000_0000;
    drive_cycle(1'b0, 1'b0, 1'b1);
    for (int i = -1; i < 20; i++) begin
      if (i >= 0) drive_cycle(1'b0, 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs_v = {sg.sign, sg.mag, sg.sample_valid, sg.chip_strobe, sg.epoch, sg.chip_cnt};
      n_run++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL prn1 cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
      if (i >= 0 && i % 2 == 0) chips[9 - i / 2] = sg.sign;
      if (i >= 0 && sg.chip_strobe === 1'b1) strobes++;
    end
    n_run++;
    if (chips !== 10'b1100100000) begin
      n_fail++;
      $display("FAIL prn1_chips got=%b exp=%b", chips, 10'b1100100000);
    end
    n_run++;
    if (strobes != 10) begin
      n_fail++;
      $display("FAIL prn1_strobes got=%0d exp=10", strobes);
    end
  endtask

  task automatic test_epoch();
    int         epochs;
    logic [9:0] chips;
    epochs = 0;
    chips  = '0;
    c_ta = 2; c_tb = 6; c_cf = '0; c_df = 32'h8000_0000;
    drive_cycle(1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 2066; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs_v = {sg.sign, sg.mag, sg.sample_valid, sg.chip_strobe, sg.epoch, sg.chip_cnt};
      n_run++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL epoch_run cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
      if (sg.epoch === 1'b1) begin
        epochs++;
        n_run++;
        if (i != 2045 || sg.chip_strobe !== 1'b1 || sg.chip_cnt !== 10'd0) begin
          n_fail++;
          $display("FAIL epoch_pos cyc=%0d got strobe=%b cnt=%0d exp cyc=2045 strobe=1 cnt=0",
                   i, sg.chip_strobe, sg.chip_cnt);
        end
      end
      if (i >= 2046 && i % 2 == 0) chips[9 - (i - 2046) / 2] = sg.sign;
    end
    n_run++;
    if (epochs != 1) begin
      n_fail++;
      $display("FAIL epoch_count got=%0d exp=1", epochs);
    end
    n_run++;
    if (chips !== 10'b1100100000) begin
      n_fail++;
      $display("FAIL epoch_repeat got=%b exp=%b", chips, 10'b1100100000);
    end
  endtask

  task automatic test_carrier();
    logic [7:0] signs, mags;
    c_ta = 2; c_tb = 6; c_cf = 32'h4000_0000; c_df = '0;
    drive_cycle(1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs_v = {sg.sign, sg.mag, sg.sample_valid, sg.chip_strobe, sg.epoch, sg.chip_cnt};
      n_run++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL carrier cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
      signs[7 - i] = sg.sign;
      mags[7 - i]  = sg.mag;
    end
    // PRN1 chip 0 is 1, so the carrier sign pattern 0011 appears inverted.
    n_run++;
    if (signs !== 8'b1100_1100 || mags !== 8'b0101_0101) begin
      n_fail++;
      $display("FAIL carrier_pattern got sign=%b mag=%b exp sign=11001100 mag=01010101",
               signs, mags);
    end
  endtask

  task automatic test_pause();
    c_ta = 3; c_tb = 7; c_cf = 32'h2000_0000; c_df = 32'h8000_0000;
    drive_cycle(1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 22; i++) begin
      drive_cycle(1'b0, !(i >= 7 && i < 12), 1'b0);
      exp_v = sb.pop_front();
      obs_v = {sg.sign, sg.mag, sg.sample_valid, sg.chip_strobe, sg.epoch, sg.chip_cnt};
      n_run++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL pause cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_bad_taps();
    logic [9:0] chips, g1ref;
    c_ta = 0; c_tb = 15; c_cf = '0; c_df = 32'h8000_0000;
    drive_cycle(1'b0, 1'b0, 1'b1);
    void'(sb.pop_front());
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      exp_v = sb.pop_front();
      obs_v = {sg.sign, sg.mag, sg.sample_valid, sg.chip_strobe, sg.epoch, sg.chip_cnt};
      n_run++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL bad_taps cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
      if (i % 2 == 0) begin
        chips[9 - i / 2] = sg.sign;
        g1ref[9 - i / 2] = 1'(g1out[i / 2]);
      end
    end
    n_run++;
    if (chips !== g1ref) begin
      n_fail++;
      $display("FAIL bad_taps_g1 got=%b exp=%b", chips, g1ref);
    end
  endtask

  task automatic test_back_to_back();
    c_ta = 5; c_tb = 9; c_cf = 32'h1000_0000; c_df = 32'hC000_0000;
    // Load with enable high, then a mid-run reset with load and enable high.
    for (int i = 0; i < 14; i++) begin
      drive_cycle(i == 10, 1'b1, i == 0 || i == 5 || i == 10);
      exp_v = sb.pop_front();
      obs_v = {sg.sign, sg.mag, sg.sample_valid, sg.chip_strobe, sg.epoch, sg.chip_cnt};
      n_run++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
      if (i == 5 || i == 10) begin
        n_run++;
        if (sg.chip_cnt !== 10'd0 || sg.sample_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL load_prio cyc=%0d got cnt=%0d valid=%b exp cnt=0 valid=0",
                   i, sg.chip_cnt, sg.sample_valid);
        end
      end
    end
  endtask

  initial begin
    sg.enable   = 1'b0;
    sg.cfg_load = 1'b0;
    sg.prn_tap1 = 4'd0;
    sg.prn_tap2 = 4'd0;
    sg.carr_fcw = '0;
    sg.code_fcw = '0;
    c_ta = 2; c_tb = 6; c_cf = '0; c_df = '0;
    build_codes();
    @(posedge sys_clk);
    #1;
    test_reset();
    test_prn1();
    test_epoch();
    test_carrier();
    test_pause();
    test_bad_taps();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
